// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle ops finish 1 cycle after acceptance, mul/div/rem in WIDTH+1.
// Accepts i_start only while o_ready=1; a start during a busy or done cycle is dropped.
module ula_seq #(
  parameter int WIDTH    = 32,
  parameter int ITER_MUL = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_ula_op,
  input  logic [5:0]       i_func_code,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_erro
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOT  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b101001;
  localparam logic [5:0] F_SRL  = 6'b101011;
  localparam logic [5:0] F_MUL  = 6'b100001;
  localparam logic [5:0] F_DIV  = 6'b100011;
  localparam logic [5:0] F_REM  = 6'b101000;
  localparam logic [5:0] F_SLTE = 6'b101100;
  localparam logic [5:0] F_SGT  = 6'b101101;
  localparam logic [5:0] F_SGTE = 6'b101110;
  localparam logic [5:0] F_SEQ  = 6'b101111;
  localparam logic [5:0] F_SNEQ = 6'b110000;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIM = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SW-1:0]    r_cnt;
  logic [5:0]       r_func;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_result;
  logic             r_erro;

  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_iter;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign w_sh = i_b[SW-1:0];

  // Decode and evaluate everything that completes in one cycle straight from the inputs.
  always_comb begin
    w_res  = '0;
    w_err  = 1'b0;
    w_iter = 1'b0;
    case (i_ula_op)
      4'd0: w_res = i_a + i_b;
      4'd1: w_res = i_a - i_b;
      4'd3: w_res = i_a & i_b;
      4'd4: w_res = i_a | i_b;
      4'd5: w_res = i_b << (WIDTH / 2);
      4'd6: w_res[0] = $signed(i_a) < $signed(i_b);
      4'd7: w_res = i_a << w_sh;
      4'd8: w_res = i_a >> w_sh;
      4'd2: begin
        case (i_func_code)
          F_ADD:  w_res = i_a + i_b;
          F_SUB:  w_res = i_a - i_b;
          F_AND:  w_res = i_a & i_b;
          F_OR:   w_res = i_a | i_b;
          F_NOT:  w_res = ~i_a;
          F_SLT:  w_res[0] = $signed(i_a) < $signed(i_b);
          F_SLTE: w_res[0] = $signed(i_a) <= $signed(i_b);
          F_SGT:  w_res[0] = $signed(i_a) > $signed(i_b);
          F_SGTE: w_res[0] = $signed(i_a) >= $signed(i_b);
          F_SEQ:  w_res[0] = (i_a == i_b);
          F_SNEQ: w_res[0] = (i_a != i_b);
          F_SLL:  w_res = i_a << w_sh;
          F_SRL:  w_res = i_a >> w_sh;
          F_MUL: begin
            if (ITER_MUL != 0) w_iter = 1'b1;
            else               w_err  = 1'b1;
          end
          F_DIV: begin
            if (ITER_MUL == 0) begin
              w_err = 1'b1;
            end else if (i_b == '0) begin
              w_res = '1;
              w_err = 1'b1;
            end else begin
              w_iter = 1'b1;
            end
          end
          F_REM: begin
            if (ITER_MUL == 0) begin
              w_err = 1'b1;
            end else if (i_b == '0) begin
              w_res = i_a;
              w_err = 1'b1;
            end else begin
              w_iter = 1'b1;
            end
          end
          default: w_err = 1'b1;
        endcase
      end
      default: w_err = 1'b1;
    endcase
  end

  // r_acc is the product (mul) or partial remainder (div/rem); r_x shifts the multiplicand left
  // or the dividend out / quotient in; r_y shifts the multiplier right or holds the divisor.
  always_comb begin
    w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
    w_rem_sh  = {r_acc, r_x[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_y};
    w_qbit    = ~w_diff[WIDTH];
    w_div_rem = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_div_quo = {r_x[WIDTH-2:0], w_qbit};
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) w_next = w_iter ? CALC : FIM;
      end
      CALC: begin
        if (r_cnt == '0) w_next = FIM;
      end
      FIM: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_func   <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_erro   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_func <= i_func_code;
            if (w_iter) begin
              r_acc <= '0;
              r_x   <= i_a;
              r_y   <= i_b;
              r_cnt <= SW'(WIDTH - 1);
            end else begin
              r_result <= w_res;
              r_erro   <= w_err;
            end
          end
        end
        CALC: begin
          if (r_cnt != '0) r_cnt <= r_cnt - SW'(1);
          if (r_func == F_MUL) begin
            r_acc <= w_mul_acc;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end else begin
            r_acc <= w_div_rem;
            r_x   <= w_div_quo;
          end
          if (r_cnt == '0) begin
            r_erro <= 1'b0;
            if (r_func == F_MUL)      r_result <= w_mul_acc;
            else if (r_func == F_DIV) r_result <= w_div_quo;
            else                      r_result <= w_div_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_erro   = r_erro;

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter ITER_MUL, default 1, 1 = iterative mul/div/rem, 0 = mul/div/rem rejected as illegal.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request strobe; sampled only when ready=1.
REQ-006 ULAop  in  4  operation class.
REQ-007 FuncCode  in  6  R-type function, used only when ULAop=4'b0010.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 ready  out  1  block idle, accepts start.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 result  out  WIDTH  operation result, held until next accepted start.
REQ-013 erro  out  1  illegal op or divide-by-zero, valid with done, held like result.

Function
REQ-014 Decode: ULAop 0 add, 1 sub, 3 and, 4 or, 5 lui, 6 slt, 7 sll, 8 srl, 2 R-type; other ULAop illegal.
REQ-015 R-type FuncCode: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 not, 101010 slt, 101001 sll, 101011 srl, 100001 mul, 100011 div, 101000 rem, 101100 slte, 101101 sgt, 101110 sgte, 101111 seq, 110000 sneq; others illegal.
REQ-016 Operands, ULAop and FuncCode shall be registered on acceptance; later input changes shall not affect the operation in flight.
REQ-017 add/sub wrap modulo 2^WIDTH; and/or bitwise; not = ~a.
REQ-018 lui = b << (WIDTH/2); sll/srl logical, shift amount b[log2(WIDTH)-1:0].
REQ-019 slt/slte/sgt/sgte signed two's-complement compares; seq/sneq equality; result 1 or 0 zero-extended.
REQ-020 mul = low WIDTH bits of unsigned a*b, shift-add, one bit per cycle.
REQ-021 div/rem unsigned restoring, one quotient bit per cycle; div returns quotient, rem remainder.
REQ-022 FSM states IDLE, CALC, FIM; ready=1 only in IDLE.
REQ-023 IDLE with start=1: single-cycle op, illegal op or b=0 div/rem -> FIM; mul/div/rem with legal operands -> CALC, iteration counter loaded WIDTH-1.
REQ-024 CALC: one iteration per cycle, counter decrements; at counter 0 -> FIM.
REQ-025 FIM: done=1 for exactly one cycle, result/erro updated same cycle, -> IDLE.
REQ-026 Latency from accepting edge to done: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul/div/rem.
REQ-027 start while ready=0 shall be ignored, not queued.
REQ-028 Illegal op: result 0, erro=1, latency 1.
REQ-029 div by zero: result all-ones; rem by zero: result a; erro=1, latency 1.
REQ-030 Legal ops: erro=0.
REQ-031 start asserted in the cycle of done shall not be accepted; earliest acceptance the following cycle.

Reset
REQ-032 reset=0 shall force IDLE immediately, ready=1, done=0, result=0, erro=0, counter=0, independent of clock.
REQ-033 reset mid-CALC shall abort the operation; no done pulse shall follow release.
REQ-034 First acceptance shall occur on the first rising edge with reset=1 and start=1.

Verification
REQ-035 WIDTH=32, ULAop=0, a=7, b=5, start -> next cycle done=1, result=12, erro=0.
REQ-036 ULAop=2, FuncCode=100001, a=1000, b=3000 -> done after 33 cycles, result=3000000, no second start accepted while ready=0.
REQ-037 FuncCode=100011, a=100, b=7 -> quotient 14; FuncCode=101000 same operands -> result 2; each latency 33.
REQ-038 FuncCode=100011, b=0, a=9 -> latency 1, result=FFFFFFFF, erro=1; ULAop=4'b1111 -> result 0, erro=1.
REQ-039 FuncCode=101010, a=FFFFFFFF, b=1 -> result 1; FuncCode=101101 same operands -> result 0.
REQ-040 reset pulsed low at cycle 10 of a mul -> ready=1 immediately, done never asserts, next add completes normally; repeat all scenarios with WIDTH=8.
